// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner: strobes one column at a time, debounces press and release.
// Define KEYPAD_DIGIT_SHIFT_EN to keep the last four accepted codes on digits.
module keypad_4x4_scanner #(
  parameter int SCAN_DIV         = 1000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] SAMPLES    = CNT_W'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       row_meta_reg;
  logic [3:0]       rs_reg;
  logic [DIV_W-1:0] dwell_reg;
  logic [1:0]       col_idx_reg, col_idx_next;
  logic [3:0]       col_reg, col_next;
  logic [1:0]       r_reg, r_next;
  logic [CNT_W-1:0] match_reg, match_next, match_inc;
  logic [CNT_W-1:0] release_reg, release_next, release_inc;
  logic [3:0]       key_reg, key_next;
  logic             key_valid_reg, key_valid_next;
  logic             sample_point;
  logic             low_any;
  logic [1:0]       low_idx;

  // Rows are asynchronous to clk; nothing below looks at row directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= 4'hF;
      rs_reg       <= 4'hF;
    end else begin
      row_meta_reg <= row;
      rs_reg       <= row_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_reg <= '0;
    end else if (sample_point) begin
      dwell_reg <= '0;
    end else begin
      dwell_reg <= dwell_reg + DIV_W'(1);
    end
  end

  assign sample_point = (dwell_reg == DWELL_LAST);
  assign low_any      = ~&rs_reg;
  assign match_inc    = match_reg + CNT_W'(1);
  assign release_inc  = release_reg + CNT_W'(1);

  // Several rows low in one column resolve to the lowest-index row.
  always_comb begin
    low_idx = 2'd3;
    if (!rs_reg[0]) begin
      low_idx = 2'd0;
    end else if (!rs_reg[1]) begin
      low_idx = 2'd1;
    end else if (!rs_reg[2]) begin
      low_idx = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SCAN;
      col_idx_reg   <= 2'd0;
      col_reg       <= 4'b1110;
      r_reg         <= 2'd0;
      match_reg     <= '0;
      release_reg   <= '0;
      key_reg       <= 4'h0;
      key_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_idx_reg   <= col_idx_next;
      col_reg       <= col_next;
      r_reg         <= r_next;
      match_reg     <= match_next;
      release_reg   <= release_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_idx_next   = col_idx_reg;
    r_next         = r_reg;
    match_next     = match_reg;
    release_next   = release_reg;
    key_next       = key_reg;
    key_valid_next = 1'b0;

    case (state_reg)
      SCAN: begin
        if (sample_point) begin
          if (low_any) begin
            r_next     = low_idx;
            match_next = CNT_W'(1);
            state_next = DEBOUNCE;
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (sample_point) begin
          if (low_any && (low_idx == r_reg)) begin
            if (match_inc == SAMPLES) begin
              key_next       = {r_reg, col_idx_reg};
              key_valid_next = 1'b1;
              release_next   = '0;
              state_next     = HELD;
            end else begin
              match_next = match_inc;
            end
          end else begin
            match_next   = '0;
            col_idx_next = col_idx_reg + 2'd1;
            state_next   = SCAN;
          end
        end
      end

      HELD: begin
        if (sample_point) begin
          if (low_any) begin
            release_next = '0;
          end else if (release_inc == SAMPLES) begin
            release_next = '0;
            match_next   = '0;
            col_idx_next = col_idx_reg + 2'd1;
            state_next   = SCAN;
          end else begin
            release_next = release_inc;
          end
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase

    // Registered strobe keeps col glitch-free with exactly one bit low.
    col_next = ~(4'b0001 << col_idx_next);
  end

  assign col       = col_reg;
  assign key       = key_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = (state_reg == HELD);

`ifdef KEYPAD_DIGIT_SHIFT_EN
  logic [15:0] digits_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_reg <= 16'h0000;
    end else if (key_valid_next) begin
      digits_reg <= {digits_reg[11:0], key_next};
    end
  end

  assign digits = digits_reg;
`else
  assign digits = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Scoreboard bench for keypad_4x4_scanner with SCAN_DIV=4, DEBOUNCE_SAMPLES=2.
module tb_keypad_4x4_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  logic [15:0] pressed = 16'h0000;
  logic [3:0]  glitch = 4'hF;
  logic [15:0] model_digits = 16'h0000;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [3:0]  key;
    logic [15:0] digits;
  } exp_t;

  exp_t exp_q[$];

  keypad_4x4_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SAMPLES(DS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .key(key),
    .key_valid(key_valid),
    .key_held(key_held),
    .digits(digits)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed switch pulls its row low while its column is strobed.
  always_comb begin
    row = glitch;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic       prev;
    logic [3:0] last_key;
    prev     = 1'b0;
    last_key = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev     = 1'b0;
        last_key = 4'h0;
      end else begin
        if (key_valid) begin
          check("kv_single_cycle", {15'b0, prev}, 16'h0000);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key_valid: got key %h expected no key_valid", key);
          end else begin
            e = exp_q.pop_front();
            $display("key_valid key=%h digits=%h (expected key=%h digits=%h)", key, digits, e.key, e.digits);
            check("key", {12'b0, key}, {12'b0, e.key});
            check("digits", digits, e.digits);
            check("held_with_valid", {15'b0, key_held}, 16'h0001);
          end
          last_key = key;
        end else begin
          check("key_stable", {12'b0, key}, {12'b0, last_key});
        end
        prev = key_valid;
      end
    end
  end

  task automatic wait_for_held(input logic level, input string name, output int cycles);
    cycles = 0;
    while (key_held !== level && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check(name, {15'b0, key_held}, {15'b0, level});
  endtask

  task automatic wait_col_enter(input logic [3:0] target, input string name);
    logic [3:0] prev_col;
    logic       found;
    int         n;
    prev_col = col;
    found    = 1'b0;
    n        = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (col == target && prev_col != target) found = 1'b1;
      prev_col = col;
    end
    check(name, {15'b0, found}, 16'h0001);
  endtask

  task automatic expect_key(input logic [3:0] k);
    exp_t e;
`ifdef KEYPAD_DIGIT_SHIFT_EN
    model_digits = {model_digits[11:0], k};
`endif
    e.key    = k;
    e.digits = model_digits;
    exp_q.push_back(e);
  endtask

  task automatic press_keys(input logic [15:0] mask, input logic [3:0] k);
    int         cyc;
    logic [1:0] nc;
    logic [3:0] exp_col;
    expect_key(k);
    exp_col = ~(4'b0001 << k[1:0]);
    nc      = k[1:0] + 2'd1;
    pressed = mask;
    wait_for_held(1'b1, "held_rise", cyc);
    check("col_frozen", {12'b0, col}, {12'b0, exp_col});
    repeat (12) @(negedge clk);
    check("held_while_pressed", {15'b0, key_held}, 16'h0001);
    check("col_still_frozen", {12'b0, col}, {12'b0, exp_col});
    pressed = 16'h0000;
    wait_for_held(1'b0, "held_fall", cyc);
    check("release_debounced", {15'b0, (cyc >= 5)}, 16'h0001);
    check("col_after_release", {12'b0, col}, {12'b0, ~(4'b0001 << nc)});
    repeat (8) @(negedge clk);
  endtask

  initial begin : stimulus
    logic [1:0] idx;
    int         cyc;

    // Reset and free-running scan with no keys.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", {12'b0, col}, 16'h000E);
    check("rst_key", {12'b0, key}, 16'h0000);
    check("rst_key_valid", {15'b0, key_valid}, 16'h0000);
    check("rst_key_held", {15'b0, key_held}, 16'h0000);
    check("rst_digits", digits, 16'h0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      idx = 2'((k / 4) % 4);
      check("idle_col_seq", {12'b0, col}, {12'b0, ~(4'b0001 << idx)});
    end

    // Key 6: row1 on col2.
    press_keys(16'h0040, 4'h6);

    // One-sample bounce on row0 while col1 is strobed.
    wait_col_enter(4'b1101, "align_col1");
    glitch = 4'b1110;
    repeat (4) @(negedge clk);
    check("bounce_col_frozen", {12'b0, col}, 16'h000D);
    glitch = 4'hF;
    repeat (4) @(negedge clk);
    check("bounce_resume_next_col", {12'b0, col}, 16'h000B);

    // Reset in the middle of debounce abandons the key.
    wait_col_enter(4'b1011, "align_col2");
    glitch = 4'b1101;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("dbrst_col", {12'b0, col}, 16'h000E);
    check("dbrst_held", {15'b0, key_held}, 16'h0000);
    glitch = 4'hF;
    model_digits = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("dbrst_restart_col0", {12'b0, col}, 16'h000E);
    @(negedge clk);
    check("dbrst_next_col1", {12'b0, col}, 16'h000D);

    // Digit history.
    press_keys(16'h0002, 4'h1);
    press_keys(16'h0004, 4'h2);
    press_keys(16'h0008, 4'h3);
    press_keys(16'h0400, 4'hA);
    check("digits_four_keys", digits, model_digits);
    press_keys(16'h8000, 4'hF);
    check("digits_fifth_key", digits, model_digits);

    // Rows 1 and 3 on col0 resolve to row1.
    press_keys(16'h1010, 4'h4);

    // Repeated identical key still pulses.
    press_keys(16'h1000, 4'hC);
    press_keys(16'h1000, 4'hC);

    // Reset while a key is held.
    expect_key(4'h9);
    pressed = 16'h0200;
    wait_for_held(1'b1, "held_before_rst", cyc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("hrst_held", {15'b0, key_held}, 16'h0000);
    check("hrst_col", {12'b0, col}, 16'h000E);
    check("hrst_digits", digits, 16'h0000);
    check("hrst_key", {12'b0, key}, 16'h0000);
    check("hrst_key_valid", {15'b0, key_valid}, 16'h0000);
    pressed = 16'h0000;
    model_digits = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("hrst_no_held", {15'b0, key_held}, 16'h0000);

    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
